// File: rtl/sd_receiver_pkg.sv
// rtl/sd_receiver_pkg.sv - shared SD definitions for the receive path
package sd_receiver_pkg;

  // response_type encodings; RT_RSVD is received exactly like R1
  typedef enum logic [1:0] {
    RT_R1   = 2'b00,
    RT_R7   = 2'b01,
    RT_DATA = 2'b10,
    RT_RSVD = 2'b11
  } resp_type_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    RECEIVE    = 3'd2,
    CRC        = 3'd3,
    DONE       = 3'd4
  } rx_state_t;

  localparam logic [7:0]  DATA_TOKEN = 8'hFE;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int          BLOCK_BITS = 4096;
  localparam int          R1_BITS    = 8;
  localparam int          R7_BITS    = 40;
  localparam int          CRC_BITS   = 16;
  localparam int          CNT_W      = 13;

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - serial CRC16-CCITT LFSR, MSB-first, initial value zero
module sd_crc16
  import sd_receiver_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic        data_in,
  output logic [15:0] crc
);

  logic feedback;

  assign feedback = crc[15] ^ data_in;

  // Shift one bit per enabled cycle; clear wins over enable so a new block starts from zero
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sd_receiver.sv
// rtl/sd_receiver.sv - SD SPI-mode response and data block receiver
module sd_receiver
  import sd_receiver_pkg::*;
#(
  parameter int RESP_TIMEOUT = 80,
  parameter int DATA_TIMEOUT = 8192
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  miso,
  input  logic [1:0]            response_type,
  input  logic                  rx_start,
  output logic [39:0]           response,
  output logic [BLOCK_BITS-1:0] data,
  output logic                  rx_valid,
  output logic                  crc_error,
  output logic                  timeout,
  output logic                  busy
);

  // The down-counter is loaded with (N-1) and the phase ends on the sample taken at zero,
  // so a 13-bit counter covers the full 8192-bit data timeout.
  localparam logic [CNT_W-1:0] RESP_LOAD  = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DATA_LOAD  = CNT_W'(DATA_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLOCK_LOAD = CNT_W'(BLOCK_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_LOAD   = CNT_W'(CRC_BITS - 1);
  // The response start bit is already bit 0, so RECEIVE takes the remaining N-1 bits
  localparam logic [CNT_W-1:0] R1_LOAD    = CNT_W'(R1_BITS - 2);
  localparam logic [CNT_W-1:0] R7_LOAD    = CNT_W'(R7_BITS - 2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  rx_state_t        state;
  rx_state_t        state_next;
  resp_type_t       rtype;
  logic             rx_start_q;
  logic             start_edge;
  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_zero;
  logic [6:0]       token_win;
  logic [7:0]       token_next;
  logic [14:0]      crc_rx;
  logic [15:0]      crc_calc;
  logic             data_mode;
  logic             start_seen;
  logic [CNT_W-1:0] recv_load;
  logic             crc_clear;
  logic             crc_enable;

  assign start_edge = rx_start & ~rx_start_q;
  assign data_mode  = (rtype == RT_DATA);
  assign cnt_zero   = (bit_cnt == '0);
  assign token_next = {token_win, miso};
  // A start condition is checked before the timeout so a start on the last allowed sample wins
  assign start_seen = data_mode ? (token_next == DATA_TOKEN) : (miso == 1'b0);
  assign recv_load  = (rtype == RT_R7) ? R7_LOAD : R1_LOAD;

  sd_crc16 u_crc16 (
    .clock   (clock),
    .reset   (reset),
    .clear   (crc_clear),
    .enable  (crc_enable),
    .data_in (miso),
    .crc     (crc_calc)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one miso sample per cycle in every receiving state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_edge) state_next = WAIT_START;
      end
      WAIT_START: begin
        if (start_seen)    state_next = RECEIVE;
        else if (cnt_zero) state_next = DONE;
      end
      RECEIVE: begin
        if (cnt_zero) state_next = data_mode ? CRC : DONE;
      end
      CRC: begin
        if (cnt_zero) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs: status flags and CRC engine control
  always_comb begin
    rx_valid   = 1'b0;
    busy       = 1'b0;
    crc_clear  = 1'b0;
    crc_enable = 1'b0;
    case (state)
      IDLE:    crc_clear  = start_edge;
      RECEIVE: crc_enable = data_mode;
      DONE:    rx_valid   = 1'b1;
      default: ;
    endcase
    busy = (state != IDLE);
  end

  // Datapath: edge detect, counter, shift registers and result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_start_q <= 1'b0;
      rtype      <= RT_R1;
      bit_cnt    <= '0;
      token_win  <= '0;
      crc_rx     <= '0;
      response   <= '0;
      data       <= '0;
      crc_error  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      rx_start_q <= rx_start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            rtype     <= resp_type_t'(response_type);
            bit_cnt   <= (response_type == RT_DATA) ? DATA_LOAD : RESP_LOAD;
            token_win <= '0;
            crc_rx    <= '0;
            response  <= '0;
            crc_error <= 1'b0;
            timeout   <= 1'b0;
          end
        end
        WAIT_START: begin
          token_win <= token_next[6:0];
          if (start_seen) begin
            if (data_mode) begin
              bit_cnt <= BLOCK_LOAD;
            end else begin
              response <= {response[38:0], miso};
              bit_cnt  <= recv_load;
            end
          end else if (cnt_zero) begin
            timeout  <= 1'b1;
            response <= '1;
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end
        RECEIVE: begin
          if (data_mode) begin
            data <= {data[BLOCK_BITS-2:0], miso};
          end else begin
            response <= {response[38:0], miso};
          end
          bit_cnt <= cnt_zero ? CRC_LOAD : (bit_cnt - CNT_ONE);
        end
        CRC: begin
          crc_rx <= {crc_rx[13:0], miso};
          if (cnt_zero) begin
            crc_error <= ({crc_rx, miso} != crc_calc);
          end else begin
            bit_cnt <= bit_cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
